dm_lsu_ctrl: RTL

//  Load/store sequencer between the core's MEM stage and the word-wide data memory (DM).
//  - Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses.
//  - Sub-word stores use read-modify-write, because DM writes whole words only.
//  - Stalls the core until the access completes.
//  - Flags misaligned, out-of-window and illegal-size accesses without touching DM.

---
 rtl/dm_lsu_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dm_lsu_ctrl.sv
// Load/store sequencer between the core MEM stage and a word-wide data memory.
// Sub-word stores are done as read-modify-write; rejected accesses never reach the memory.
module dm_lsu_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h6600_0000,
  parameter logic [31:0] LIMIT_ADDR = 32'h6600_00FC
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic        fault_q;
  logic [2:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wd_q;
  logic [31:0] buf_q;
  logic        req_fault;
  logic        accept;

  function automatic logic classify_fault(input logic we, input logic [2:0] size,
                                          input logic [31:0] addr);
    logic        bad_size;
    logic        misal;
    logic [31:0] wa;
    wa       = {addr[31:2], 2'b00};
    bad_size = (size == 3'b011) || (size[2:1] == 2'b11) || (we && size[2]);
    misal    = ((size[1:0] == 2'b01) && addr[0]) ||
               ((size[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    return bad_size || misal || (wa < BASE_ADDR) || (wa > LIMIT_ADDR);
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] size,
                                              input logic [1:0] lane);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] r;
    case (lane)
      2'd0:    b_s = word[7:0];
      2'd1:    b_s = word[15:8];
      2'd2:    b_s = word[23:16];
      default: b_s = word[31:24];
    endcase
    h_s = lane[1] ? word[31:16] : word[15:0];
    case (size)
      3'b000:  r = 32'(b_s);
      3'b001:  r = 32'(h_s);
      3'b100:  r = {24'h0, b_s};
      3'b101:  r = {16'h0, h_s};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [2:0] size,
                                             input logic [1:0] lane, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (size[1:0] == 2'b00) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0]  = wd;
    end
    return r;
  endfunction

  assign req_fault = classify_fault(core_we_i, core_size_i, core_addr_i);
  assign accept    = (state_q == IDLE) && core_req_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (core_req_i) begin
        if (req_fault)                              state_d = DONE;
        else if (core_we_i && core_size_i == 3'b010) state_d = WR;
        else                                        state_d = RD;
      end
      RD:      state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o    = (state_q == RD) || (state_q == WR);
    mem_we_o     = (state_q == WR);
    core_stall_o = accept || (state_q == RD) || (state_q == WR);
    core_fault_o = (state_q == DONE) && fault_q;
    core_rd_o    = 32'h0;
    if (state_q == DONE && !we_q && !fault_q) core_rd_o = extend_load(buf_q, size_q, lane_q);
  end

  // Address and write word are registered so they hold their value between accesses.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      size_q   <= 3'b000;
      lane_q   <= 2'b00;
      wd_q     <= 16'h0;
      buf_q    <= 32'h0;
      mem_a_o  <= 32'h0;
      mem_wd_o <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= core_we_i;
        fault_q <= req_fault;
        size_q  <= core_size_i;
        lane_q  <= core_addr_i[1:0];
        wd_q    <= core_wd_i[15:0];
        if (!req_fault) begin
          mem_a_o <= {core_addr_i[31:2], 2'b00};
          if (core_we_i && core_size_i == 3'b010) mem_wd_o <= core_wd_i;
        end
      end
      if (state_q == RD) begin
        buf_q <= mem_rd_i;
        if (we_q) mem_wd_o <= merge_lane(mem_rd_i, size_q, lane_q, wd_q);
      end
    end
  end

endmodule
